// File: rtl/sa_aw_channel_arb_pkg.sv
// ---------------------------------------------------------------------------
// sa_aw_channel_arb_pkg
// Shared definitions for the slave-arbiter AW channel (and the AR channel
// that reuses sa_rr_arbiter).
//   - idx_w()       : master index width; $clog2 with a floor of 1 bit
//   - *_DEF         : default channel widths
//   - aw_payload_t  : one buffered AW request as presented to the slave
// No ports (package).
// ---------------------------------------------------------------------------
package sa_aw_channel_arb_pkg;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned MST_AMT_DEF           = 3;
   localparam int unsigned MST_ID_W_DEF          = idx_w(MST_AMT_DEF);
   localparam int unsigned ADDR_WIDTH_DEF        = 32;
   localparam int unsigned TRANS_MST_ID_W_DEF    = 5;
   localparam int unsigned TRANS_SLV_ID_W_DEF    = TRANS_MST_ID_W_DEF + MST_ID_W_DEF;
   localparam int unsigned TRANS_DATA_LEN_W_DEF  = 3;
   localparam int unsigned TRANS_DATA_SIZE_W_DEF = 3;
   localparam int unsigned TRANS_BURST_W_DEF     = 2;

   // Slave-side request queue depth; the queue uses 1-bit pointers.
   localparam int unsigned AW_QUEUE_DEPTH = 2;

   // id carries {master index, master AWID} so responses can be routed back.
   typedef struct packed {
      logic [TRANS_SLV_ID_W_DEF-1:0]    id;
      logic [ADDR_WIDTH_DEF-1:0]        addr;
      logic [TRANS_BURST_W_DEF-1:0]     burst;
      logic [TRANS_DATA_LEN_W_DEF-1:0]  len;
      logic [TRANS_DATA_SIZE_W_DEF-1:0] size;
   } aw_payload_t;

endpackage

// File: rtl/sa_aw_channel_arb_if.sv
// ---------------------------------------------------------------------------
// sa_aw_channel_arb_if
// Bundles the AW-channel signals around one slave arbiter:
//   dsp_*      : packed per-master requests from the master dispatchers
//                (master m occupies [W*(m+1)-1 -: W]) and one-hot AWREADY
//   m_*        : queue head toward the slave, with slave AWREADY
//   AW_*       : order-FIFO push toward the W channel, and its full/stall
// Modports:
//   slave  : the arbiter side (consumes dsp requests, drives m_* and AW_*)
//   master : the environment side (dispatchers, slave, W-channel order FIFO)
// ---------------------------------------------------------------------------
interface sa_aw_channel_arb_if
   import sa_aw_channel_arb_pkg::*;
#(
   parameter int unsigned MST_AMT           = MST_AMT_DEF,
   parameter int unsigned MST_ID_W          = idx_w(MST_AMT),
   parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF,
   parameter int unsigned TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
   parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
   parameter int unsigned TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
   parameter int unsigned TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
   parameter int unsigned TRANS_BURST_W     = TRANS_BURST_W_DEF
) ();

   logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AWID_i;
   logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AWADDR_i;
   logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_AWBURST_i;
   logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AWLEN_i;
   logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AWSIZE_i;
   logic [MST_AMT-1:0]                   dsp_AWVALID_i;
   logic [MST_AMT-1:0]                   dsp_slv_sel_i;
   logic [MST_AMT-1:0]                   dsp_AWREADY_o;

   logic [TRANS_SLV_ID_W-1:0]            m_AWID_o;
   logic [ADDR_WIDTH-1:0]                m_AWADDR_o;
   logic [TRANS_BURST_W-1:0]             m_AWBURST_o;
   logic [TRANS_DATA_LEN_W-1:0]          m_AWLEN_o;
   logic [TRANS_DATA_SIZE_W-1:0]         m_AWSIZE_o;
   logic                                 m_AWVALID_o;
   logic                                 m_AWREADY_i;

   logic [MST_ID_W-1:0]                  AW_mst_id_o;
   logic [TRANS_DATA_LEN_W-1:0]          AW_AxLEN_o;
   logic                                 AW_fifo_order_wr_en_o;
   logic                                 AW_stall_i;

   modport slave (
      input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i,
      input  dsp_AWVALID_i, dsp_slv_sel_i, m_AWREADY_i, AW_stall_i,
      output dsp_AWREADY_o, m_AWID_o, m_AWADDR_o, m_AWBURST_o, m_AWLEN_o, m_AWSIZE_o,
      output m_AWVALID_o, AW_mst_id_o, AW_AxLEN_o, AW_fifo_order_wr_en_o
   );

   modport master (
      output dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i,
      output dsp_AWVALID_i, dsp_slv_sel_i, m_AWREADY_i, AW_stall_i,
      input  dsp_AWREADY_o, m_AWID_o, m_AWADDR_o, m_AWBURST_o, m_AWLEN_o, m_AWSIZE_o,
      input  m_AWVALID_o, AW_mst_id_o, AW_AxLEN_o, AW_fifo_order_wr_en_o
   );

endinterface

// File: rtl/sa_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sa_rr_arbiter
// Combinational round-robin pick: first requester at or above i_rr_ptr,
// wrapping modulo N. Pointer ownership stays with the caller.
// Ports:
//   i_req      [N]      request vector
//   i_rr_ptr   [IDX_W]  highest-priority index (must be < N)
//   o_gnt      [N]      one-hot grant (all zero when no request)
//   o_gnt_idx  [IDX_W]  granted index (0 when no request)
//   o_gnt_vld           any request present
// ---------------------------------------------------------------------------
module sa_rr_arbiter
   import sa_aw_channel_arb_pkg::*;
#(
   parameter int unsigned N     = MST_AMT_DEF,
   parameter int unsigned IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_rr_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_vld
);

   int unsigned      w_idx;
   logic [IDX_W-1:0] w_sel;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_idx     = 0;
      w_sel     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         // Explicit wrap: N need not be a power of two.
         w_idx = 32'(i_rr_ptr) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         w_sel = IDX_W'(w_idx);
         if (!o_gnt_vld && i_req[w_sel]) begin
            o_gnt_vld    = 1'b1;
            o_gnt[w_sel] = 1'b1;
            o_gnt_idx    = w_sel;
         end
      end
   end

endmodule

// File: rtl/sa_aw_channel_arb.sv
// ---------------------------------------------------------------------------
// sa_aw_channel_arb
// Slave-arbiter write-address stage. Round-robin grants one AW request per
// cycle among masters addressing this slave, buffers accepted requests in a
// 2-entry queue toward the slave, and pushes {master index, AWLEN} into the
// W channel's order FIFO in the same cycle as each acceptance.
// Ports:
//   ACLK_i    clock
//   ARESET_i  asynchronous reset, active-high
//   bus       sa_aw_channel_arb_if.slave (dsp_* requests, m_* toward slave,
//             AW_* order-FIFO push and stall)
// ---------------------------------------------------------------------------
module sa_aw_channel_arb
   import sa_aw_channel_arb_pkg::*;
#(
   parameter int unsigned MST_AMT           = MST_AMT_DEF,
   parameter int unsigned MST_ID_W          = idx_w(MST_AMT),
   parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF,
   parameter int unsigned TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
   parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
   parameter int unsigned TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
   parameter int unsigned TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
   parameter int unsigned TRANS_BURST_W     = TRANS_BURST_W_DEF
) (
   input logic                ACLK_i,
   input logic                ARESET_i,
   sa_aw_channel_arb_if.slave bus
);

   logic [MST_AMT-1:0]        w_req;
   logic [MST_AMT-1:0]        w_gnt;
   logic [MST_ID_W-1:0]       w_gnt_idx;
   logic                      w_gnt_vld;
   logic [MST_ID_W-1:0]       w_rr_next;
   logic                      w_pop;
   logic                      w_accept;
   logic [TRANS_SLV_ID_W-1:0] w_push_id;
   aw_payload_t               w_push;
   aw_payload_t               w_head;

   logic [MST_ID_W-1:0]       r_rr_ptr;
   aw_payload_t               r_q [AW_QUEUE_DEPTH];
   logic                      r_rd_ptr;
   logic                      r_wr_ptr;
   logic [1:0]                r_count;

   assign w_req = bus.dsp_AWVALID_i & bus.dsp_slv_sel_i;

   sa_rr_arbiter #(
      .N     (MST_AMT),
      .IDX_W (MST_ID_W)
   ) u_rr_arbiter (
      .i_req     (w_req),
      .i_rr_ptr  (r_rr_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   assign w_pop = bus.m_AWVALID_o & bus.m_AWREADY_i;

   // A full queue still accepts when the head leaves in the same cycle.
   assign w_accept = w_gnt_vld & ~bus.AW_stall_i & ((r_count < 2'd2) | w_pop) & ~ARESET_i;

   assign w_rr_next = (w_gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : w_gnt_idx + 1'b1;

   assign w_push_id = {w_gnt_idx, bus.dsp_AWID_i[w_gnt_idx*TRANS_MST_ID_W +: TRANS_MST_ID_W]};

   always_comb begin
      w_push       = '0;
      w_push.id    = w_push_id;
      w_push.addr  = bus.dsp_AWADDR_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_push.burst = bus.dsp_AWBURST_i[w_gnt_idx*TRANS_BURST_W +: TRANS_BURST_W];
      w_push.len   = bus.dsp_AWLEN_i[w_gnt_idx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      w_push.size  = bus.dsp_AWSIZE_i[w_gnt_idx*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
   end

   // Grant-side outputs: index/len follow the arbiter even without an accept.
   assign bus.dsp_AWREADY_o         = w_accept ? w_gnt : '0;
   assign bus.AW_fifo_order_wr_en_o = w_accept;
   assign bus.AW_mst_id_o           = w_gnt_idx;
   assign bus.AW_AxLEN_o            = bus.dsp_AWLEN_i[w_gnt_idx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];

   // Queue toward the slave. With a pop at full, wr_ptr == rd_ptr, so the
   // new entry lands in the slot that is leaving this cycle.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         r_rr_ptr <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < AW_QUEUE_DEPTH; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_q[r_wr_ptr] <= w_push;
            r_wr_ptr      <= ~r_wr_ptr;
            r_rr_ptr      <= w_rr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
      end
   end

   assign w_head = r_q[r_rd_ptr];

   assign bus.m_AWVALID_o = (r_count != 2'd0);
   assign bus.m_AWID_o    = w_head.id;
   assign bus.m_AWADDR_o  = w_head.addr;
   assign bus.m_AWBURST_o = w_head.burst;
   assign bus.m_AWLEN_o   = w_head.len;
   assign bus.m_AWSIZE_o  = w_head.size;

endmodule
